// File: rtl/usb_rx_bit_decoder_if.sv
// -----------------------------------------------------------------------------
// usb_rx_bit_decoder_if
//
// Groups the signals between the USB receive bit decoder and its neighbours:
// the receive control FSM, the line synchronizers and the 8-bit shift register.
//
// Signals:
//   rcving        ctrl  -> dec  high while a packet is being received
//   d_plus_sync   sync  -> dec  D+ already synchronized to clk
//   d_minus_sync  sync  -> dec  D- already synchronized to clk
//   d_orig        dec   -> sreg decoded data bit, held between bits
//   shift_enable  dec   -> sreg one-cycle pulse: shift d_orig in
//   byte_received dec   -> ctrl one-cycle pulse: shift register holds a byte
//   eop           dec   -> ctrl one-cycle pulse: SE0 seen at a sample point
//   stuff_error   dec   -> ctrl one-cycle pulse: stuffed bit was not a 0
//
// Modports:
//   master  the environment driving the line and rcving
//   slave   the decoder itself
// -----------------------------------------------------------------------------
interface usb_rx_bit_decoder_if;
    logic rcving;
    logic d_plus_sync;
    logic d_minus_sync;
    logic d_orig;
    logic shift_enable;
    logic byte_received;
    logic eop;
    logic stuff_error;

    modport master (
        output rcving, d_plus_sync, d_minus_sync,
        input  d_orig, shift_enable, byte_received, eop, stuff_error
    );

    modport slave (
        input  rcving, d_plus_sync, d_minus_sync,
        output d_orig, shift_enable, byte_received, eop, stuff_error
    );
endinterface

// File: rtl/usb_rx_bit_decoder.sv
// -----------------------------------------------------------------------------
// usb_rx_bit_decoder
//
// Front end of the USB receive path. Recovers bit timing from the synchronized
// D+ line, NRZI-decodes the sampled bits, strips stuffed bits and feeds the
// LSB-first receive shift register. Reports byte completion, end-of-packet
// (SE0) and bit-stuff violations to the receive control FSM.
//
// Parameters:
//   CLKS_PER_BIT  system clocks per USB bit period
//   SAMPLE_POINT  bit-timer value at which the line is sampled
//   MAX_ONES      consecutive decoded 1s after which a stuffed 0 follows
//
// Ports:
//   clk    system clock, rising edge
//   n_rst  asynchronous active-low reset
//   bus    usb_rx_bit_decoder_if.slave (line inputs, rcving, decoder outputs)
// -----------------------------------------------------------------------------
module usb_rx_bit_decoder #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_POINT = 3,
    parameter int MAX_ONES     = 6
) (
    input  logic                  clk,
    input  logic                  n_rst,
    usb_rx_bit_decoder_if.slave   bus
);

    localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int OW = $clog2(MAX_ONES + 1);

    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TIMER_SMP  = TW'(SAMPLE_POINT);
    localparam logic [OW-1:0] ONES_MAX   = OW'(MAX_ONES);

    // Registered state
    logic [TW-1:0] timer;
    logic          prev_dp;
    logic          prev_raw;
    logic [OW-1:0] ones_cnt;
    logic [2:0]    bit_cnt;
    logic          byte_done;   // 8th bit is being shifted this cycle

    // Next-state values
    logic [TW-1:0] timer_next;
    logic          prev_raw_next;
    logic [OW-1:0] ones_cnt_next;
    logic [2:0]    bit_cnt_next;
    logic          byte_done_next;
    logic          d_orig_next;
    logic          shift_next;
    logic          eop_next;
    logic          stuff_err_next;

    logic line_edge;
    logic sample;
    logic se0;
    logic bit_val;

    assign line_edge = (bus.d_plus_sync != prev_dp);
    assign sample    = (timer == TIMER_SMP);
    assign se0       = ~bus.d_plus_sync & ~bus.d_minus_sync;
    // NRZI: no transition since the previous sample decodes as 1.
    assign bit_val   = (bus.d_plus_sync == prev_raw);

    // NOTE: every variable gets a default before any branch, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        // Any D+ transition re-aligns the timer; otherwise it free-runs so long
        // runs of 1s (no transitions) are still sampled once per bit period.
        if (line_edge || timer == TIMER_LAST) begin
            timer_next = '0;
        end else begin
            timer_next = timer + 1'b1;
        end

        prev_raw_next  = prev_raw;
        ones_cnt_next  = ones_cnt;
        bit_cnt_next   = bit_cnt;
        byte_done_next = 1'b0;
        d_orig_next    = bus.d_orig;
        shift_next     = 1'b0;
        eop_next       = 1'b0;
        stuff_err_next = 1'b0;

        if (sample) begin
            if (se0) begin
                // End of packet: the next packet decodes relative to J.
                eop_next      = 1'b1;
                bit_cnt_next  = '0;
                ones_cnt_next = '0;
                prev_raw_next = 1'b1;
            end else begin
                prev_raw_next = bus.d_plus_sync;
                if (ones_cnt == ONES_MAX) begin
                    // Stuffed position: dropped, and must have been a 0.
                    ones_cnt_next  = '0;
                    stuff_err_next = bit_val;
                end else begin
                    shift_next     = 1'b1;
                    d_orig_next    = bit_val;
                    ones_cnt_next  = bit_val ? ones_cnt + 1'b1 : '0;
                    bit_cnt_next   = bit_cnt + 3'd1;
                    byte_done_next = (bit_cnt == 3'd7);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            timer             <= '0;
            prev_dp           <= 1'b1;
            prev_raw          <= 1'b1;
            ones_cnt          <= '0;
            bit_cnt           <= '0;
            byte_done         <= 1'b0;
            bus.d_orig        <= 1'b1;
            bus.shift_enable  <= 1'b0;
            bus.byte_received <= 1'b0;
            bus.eop           <= 1'b0;
            bus.stuff_error   <= 1'b0;
        end else if (!bus.rcving) begin
            // Idle: park everything at reset values; a partial byte is lost.
            timer             <= '0;
            prev_dp           <= 1'b1;
            prev_raw          <= 1'b1;
            ones_cnt          <= '0;
            bit_cnt           <= '0;
            byte_done         <= 1'b0;
            bus.d_orig        <= 1'b1;
            bus.shift_enable  <= 1'b0;
            bus.byte_received <= 1'b0;
            bus.eop           <= 1'b0;
            bus.stuff_error   <= 1'b0;
        end else begin
            timer             <= timer_next;
            prev_dp           <= bus.d_plus_sync;
            prev_raw          <= prev_raw_next;
            ones_cnt          <= ones_cnt_next;
            bit_cnt           <= bit_cnt_next;
            byte_done         <= byte_done_next;
            bus.d_orig        <= d_orig_next;
            bus.shift_enable  <= shift_next;
            // One cycle after the 8th shift, when the register holds the byte.
            bus.byte_received <= byte_done;
            bus.eop           <= eop_next;
            bus.stuff_error   <= stuff_err_next;
        end
    end

endmodule

// File: tb/tb_usb_rx_bit_decoder.sv
// -----------------------------------------------------------------------------
// tb_usb_rx_bit_decoder
//
// Drives NRZI-encoded, bit-stuffed USB traffic into usb_rx_bit_decoder and
// compares every output on every cycle against a behavioural model. A local
// 8-bit LSB-first shift register rebuilds the received bytes, which are
// compared with the bytes that were sent. Directed scenarios carry literal
// expectations (pulse counts, byte values) as well.
// -----------------------------------------------------------------------------
module tb_usb_rx_bit_decoder;

    localparam int CPB  = 8;
    localparam int SP   = 3;
    localparam int MAXO = 6;

    logic clk = 1'b0;
    logic n_rst;

    usb_rx_bit_decoder_if bus ();

    usb_rx_bit_decoder #(
        .CLKS_PER_BIT (CPB),
        .SAMPLE_POINT (SP),
        .MAX_ONES     (MAXO)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- checking
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Downstream shift register (LSB first: first bit ends in bit 0)
    logic [7:0] rcv_data = 8'h00;
    always @(posedge clk) begin
        if (bus.shift_enable) rcv_data <= {bus.d_orig, rcv_data[7:1]};
    end

    logic [7:0] exp_bytes [$];

    // ------------------------------------------------------------------- model
    // The sampling phase is derived from the cycle distance to the last
    // alignment point (a D+ transition, or an idle/reset cycle).
    int   cyc    = 0;
    int   anchor = -1;
    logic m_prev_dp, m_prev_raw;
    int   m_ones, m_bits;
    logic pend_br;
    logic exp_se, exp_d, exp_br, exp_eop, exp_serr;

    // Pulse monitors for the directed scenarios
    int         se_cnt, br_cnt, eop_cnt, serr_cnt, spacing_bad, last_se_cyc;
    logic [7:0] dseq;

    task automatic clear_counts();
        se_cnt = 0; br_cnt = 0; eop_cnt = 0; serr_cnt = 0;
        spacing_bad = 0; last_se_cyc = -1; dseq = 8'h00;
    endtask

    task automatic model_idle();
        anchor     = cyc;
        m_prev_dp  = 1'b1;
        m_prev_raw = 1'b1;
        m_ones     = 0;
        m_bits     = 0;
        pend_br    = 1'b0;
        exp_se = 1'b0; exp_d = 1'b1; exp_br = 1'b0; exp_eop = 1'b0; exp_serr = 1'b0;
    endtask

    task automatic model_step();
        logic smp, bitv;
        if (!bus.rcving) begin
            model_idle();
        end else begin
            smp = (((cyc - anchor - 1) % CPB) == SP);
            if (bus.d_plus_sync != m_prev_dp) anchor = cyc;
            m_prev_dp = bus.d_plus_sync;
            exp_se = 1'b0; exp_eop = 1'b0; exp_serr = 1'b0;
            exp_br = pend_br; pend_br = 1'b0;
            if (smp) begin
                if (!bus.d_plus_sync && !bus.d_minus_sync) begin
                    exp_eop = 1'b1; m_bits = 0; m_ones = 0; m_prev_raw = 1'b1;
                end else begin
                    bitv       = (bus.d_plus_sync == m_prev_raw);
                    m_prev_raw = bus.d_plus_sync;
                    if (m_ones == MAXO) begin
                        m_ones   = 0;
                        exp_serr = bitv;
                    end else begin
                        exp_se = 1'b1;
                        exp_d  = bitv;
                        m_ones = bitv ? m_ones + 1 : 0;
                        m_bits = m_bits + 1;
                        if (m_bits == 8) begin
                            m_bits  = 0;
                            pend_br = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    // Single compare process: outputs settle after posedge, checked at negedge.
    always @(negedge clk) begin
        if (!n_rst) begin
            model_idle();
        end else begin
            check("shift_enable", bus.shift_enable, exp_se);
            check("d_orig", bus.d_orig, exp_d);
            check("byte_received", bus.byte_received, exp_br);
            check("eop", bus.eop, exp_eop);
            check("stuff_error", bus.stuff_error, exp_serr);
            if (bus.byte_received) begin
                if (exp_bytes.size() == 0) check("byte_expected", exp_bytes.size(), 1);
                else check("rcv_data", rcv_data, exp_bytes.pop_front());
                br_cnt++;
            end
            if (bus.shift_enable) begin
                if (last_se_cyc >= 0 && (cyc - last_se_cyc) != CPB) spacing_bad++;
                last_se_cyc = cyc;
                dseq = {dseq[6:0], bus.d_orig};
                se_cnt++;
            end
            if (bus.eop) eop_cnt++;
            if (bus.stuff_error) serr_cnt++;
            model_step();
        end
        cyc++;
    end

    // --------------------------------------------------------------- stimulus
    logic line_lvl;
    int   enc_ones;
    bit   jitter, jt;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_line(input logic dp, input logic dm);
        int p;
        bus.d_plus_sync  = dp;
        bus.d_minus_sync = dm;
        if (jitter) begin
            p  = jt ? 9 : 7;
            jt = ~jt;
        end else begin
            p = CPB;
        end
        tick(p);
    endtask

    task automatic send_dbit(input logic b);
        if (!b) line_lvl = ~line_lvl;
        drive_line(line_lvl, ~line_lvl);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stuff, input int nbits);
        logic [7:0] v;
        v = b;
        for (int i = 0; i < nbits; i++) begin
            send_dbit(v[i]);
            enc_ones = v[i] ? enc_ones + 1 : 0;
            if (stuff && enc_ones == MAXO) begin
                send_dbit(1'b0);
                enc_ones = 0;
            end
        end
    endtask

    task automatic start_pkt(input bit jit);
        jitter   = jit;
        jt       = 1'b0;
        line_lvl = 1'b1;
        enc_ones = 0;
        bus.rcving = 1'b1;
    endtask

    task automatic send_eop();
        drive_line(1'b0, 1'b0);
        drive_line(1'b0, 1'b0);
        line_lvl = 1'b1;
        enc_ones = 0;
    endtask

    task automatic end_pkt();
        bus.rcving       = 1'b0;
        bus.d_plus_sync  = 1'b1;
        bus.d_minus_sync = 1'b0;
        tick(6);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   nb, abort_at;
        bit   aborted;
        logic [7:0] data;

        n_rst = 1'b1;
        bus.rcving = 1'b0; bus.d_plus_sync = 1'b1; bus.d_minus_sync = 1'b0;
        jitter = 1'b0; jt = 1'b0; line_lvl = 1'b1; enc_ones = 0;
        clear_counts();
        #2 n_rst = 1'b0;
        #1;
        check("reset d_orig", bus.d_orig, 1);
        check("reset shift_enable", bus.shift_enable, 0);
        check("reset byte_received", bus.byte_received, 0);
        check("reset eop", bus.eop, 0);
        check("reset stuff_error", bus.stuff_error, 0);
        tick(2);
        n_rst = 1'b1;
        tick(3);

        // SYNC byte 0x80: decoded 0,0,0,0,0,0,0,1
        clear_counts();
        exp_bytes.push_back(8'h80);
        start_pkt(1'b0);
        send_byte(8'h80, 1'b1, 8);
        check("sync shifts", se_cnt, 8);
        check("sync spacing", spacing_bad, 0);
        check("sync d_orig seq", dseq, 8'h01);
        check("sync byte_received", br_cnt, 1);
        check("sync data", rcv_data, 8'h80);
        send_eop();
        end_pkt();

        // Stuffed 0xFF: 9 bit periods, 8 shifts, no error
        clear_counts();
        exp_bytes.push_back(8'hFF);
        start_pkt(1'b0);
        send_byte(8'hFF, 1'b1, 8);
        check("stuff shifts", se_cnt, 8);
        check("stuff no error", serr_cnt, 0);
        check("stuff byte_received", br_cnt, 1);
        check("stuff data", rcv_data, 8'hFF);
        send_eop();
        end_pkt();

        // Seven 1s without a stuffed 0
        clear_counts();
        start_pkt(1'b0);
        send_byte(8'hFF, 1'b0, 8);
        check("stuff_error pulses", serr_cnt, 1);
        check("stuff_error shifts", se_cnt, 7);
        send_eop();
        check("stuff_error no byte", br_cnt, 0);
        end_pkt();

        // EOP between bytes, then decode restarts from J
        clear_counts();
        exp_bytes.push_back(8'h3C);
        exp_bytes.push_back(8'hA5);
        start_pkt(1'b0);
        send_byte(8'h3C, 1'b1, 8);
        send_eop();
        check("eop pulses", eop_cnt, 2);
        check("eop no extra shift", se_cnt, 8);
        send_byte(8'hA5, 1'b1, 8);
        check("after eop bytes", br_cnt, 2);
        check("after eop data", rcv_data, 8'hA5);
        send_eop();
        end_pkt();

        // Alternating 7/9 clock bit periods
        clear_counts();
        exp_bytes.push_back(8'h80); exp_bytes.push_back(8'h5A);
        exp_bytes.push_back(8'hFF); exp_bytes.push_back(8'h00);
        start_pkt(1'b1);
        send_byte(8'h80, 1'b1, 8);
        send_byte(8'h5A, 1'b1, 8);
        send_byte(8'hFF, 1'b1, 8);
        send_byte(8'h00, 1'b1, 8);
        check("drift bytes", br_cnt, 4);
        check("drift last data", rcv_data, 8'h00);
        send_eop();
        end_pkt();

        // Abort after 5 bits, then a clean packet
        clear_counts();
        start_pkt(1'b0);
        send_byte(8'hC3, 1'b1, 5);
        end_pkt();
        check("abort shifts", se_cnt, 5);
        check("abort no byte", br_cnt, 0);
        exp_bytes.push_back(8'h96);
        start_pkt(1'b0);
        send_byte(8'h96, 1'b1, 8);
        check("post-abort byte", br_cnt, 1);
        check("post-abort data", rcv_data, 8'h96);
        send_eop();
        end_pkt();

        // Asynchronous reset while shift_enable is high
        start_pkt(1'b0);
        bus.d_plus_sync = 1'b0; bus.d_minus_sync = 1'b1;
        tick(5);
        check("pre-reset shift_enable", bus.shift_enable, 1);
        n_rst = 1'b0;
        #1;
        check("async rst shift_enable", bus.shift_enable, 0);
        check("async rst d_orig", bus.d_orig, 1);
        check("async rst byte_received", bus.byte_received, 0);
        check("async rst eop", bus.eop, 0);
        check("async rst stuff_error", bus.stuff_error, 0);
        tick(2);
        bus.rcving = 1'b0; bus.d_plus_sync = 1'b1; bus.d_minus_sync = 1'b0;
        n_rst = 1'b1;
        tick(4);

        // Randomized packets
        for (int p = 0; p < 14; p++) begin
            nb       = $urandom_range(1, 4);
            abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nb - 1) : -1;
            aborted  = 1'b0;
            start_pkt($urandom_range(0, 1) == 1);
            for (int b = 0; b < nb && !aborted; b++) begin
                data = 8'($urandom);
                if (b == abort_at) begin
                    send_byte(data, 1'b1, $urandom_range(1, 7));
                    aborted = 1'b1;
                end else begin
                    exp_bytes.push_back(data);
                    send_byte(data, 1'b1, 8);
                end
            end
            if (!aborted) send_eop();
            end_pkt();
        end

        check("all bytes received", exp_bytes.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
